// File: rtl/sat_ctrl_pkg.sv
// Shared types and constants for the per-thread WalkSAT controller:
// FSM states, completion codes, control-vector bit positions and width helpers.
package sat_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_SELECT_UNSAT,
        S_READ_CLAUSETAB,
        S_READ_VARTAB,
        S_EVAL_CLAUSE,
        S_WAIT_EVAL,
        S_GATHER_UNSAT,
        S_WAIT_GATHER,
        S_CHECK_SOL,
        S_RESTART,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        ST_NONE      = 2'b00,
        ST_SAT       = 2'b01,
        ST_EXHAUSTED = 2'b10,
        ST_ABORTED   = 2'b11
    } status_e;

    // Datapath control vector bit positions; two-bit fields are given by their low bit.
    localparam int CTL_SEL_VALID = 13;
    localparam int CTL_VT_RD     = 9;
    localparam int CTL_EVAL_LO   = 6;
    localparam int CTL_EVAL_EN   = 5;
    localparam int CTL_SRC_LO    = 3;
    localparam int CTL_GATHER    = 2;
    localparam int CTL_FLIP      = 1;
    localparam int CTL_SEL_REQ   = 0;

    function automatic int vaw_f(input int num_vars);
        return $clog2(num_vars);
    endfunction

    function automatic int law_f(input int num_vars);
        return $clog2(num_vars) + 1;
    endfunction

    function automatic int ct_width_f(input int num_vars, input int nsat, input int mcm);
        return law_f(num_vars) * (nsat - 1) * mcm;
    endfunction

endpackage

// File: rtl/sat_load_arbiter.sv
// Fixed-priority (ATT > CT > UCB) load acceptance with a one-cycle registered write stage.
module sat_load_arbiter #(
    parameter int ATT_AW = 13,
    parameter int ATT_DW = 31,
    parameter int CT_AW  = 11,
    parameter int CT_DW  = 480,
    parameter int UCB_AW = 11,
    parameter int UCB_DW = 36
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_active,
    input  logic [ATT_AW-1:0] att_addr,
    input  logic [ATT_DW-1:0] att_data,
    input  logic              att_valid,
    input  logic [CT_AW-1:0]  ct_addr,
    input  logic [CT_DW-1:0]  ct_data,
    input  logic              ct_valid,
    input  logic [UCB_AW-1:0] ucb_addr,
    input  logic [UCB_DW-1:0] ucb_data,
    input  logic              ucb_valid,
    output logic              att_ready,
    output logic              ct_ready,
    output logic              ucb_ready,
    output logic              att_wr_en,
    output logic [ATT_AW-1:0] att_wr_addr,
    output logic [ATT_DW-1:0] att_wr_data,
    output logic              ct_wr_en,
    output logic [CT_AW-1:0]  ct_wr_addr,
    output logic [CT_DW-1:0]  ct_wr_data,
    output logic              ucb_wr_en,
    output logic [UCB_AW-1:0] ucb_wr_addr,
    output logic [UCB_DW-1:0] ucb_wr_data,
    output logic              ucb_setup
);

    logic att_acc, ct_acc, ucb_acc;

    assign att_ready = load_active;
    assign ct_ready  = load_active & ~att_valid;
    assign ucb_ready = load_active & ~att_valid & ~ct_valid;

    assign att_acc = att_ready & att_valid;
    assign ct_acc  = ct_ready  & ct_valid;
    assign ucb_acc = ucb_ready & ucb_valid;

    // Write stage: accepted beat appears on the table write port one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            att_wr_en   <= 1'b0;
            att_wr_addr <= '0;
            att_wr_data <= '0;
            ct_wr_en    <= 1'b0;
            ct_wr_addr  <= '0;
            ct_wr_data  <= '0;
            ucb_wr_en   <= 1'b0;
            ucb_wr_addr <= '0;
            ucb_wr_data <= '0;
            ucb_setup   <= 1'b0;
        end else begin
            att_wr_en <= att_acc;
            ct_wr_en  <= ct_acc;
            ucb_wr_en <= ucb_acc;
            ucb_setup <= ucb_acc;
            if (att_acc) begin
                att_wr_addr <= att_addr;
                att_wr_data <= att_data;
            end
            if (ct_acc) begin
                ct_wr_addr <= ct_addr;
                ct_wr_data <= ct_data;
            end
            if (ucb_acc) begin
                ucb_wr_addr <= ucb_addr;
                ucb_wr_data <= ucb_data;
            end
        end
    end

endmodule

// File: rtl/sat_thread_controller.sv
// Per-thread WalkSAT controller: table loading, then the select/read/eval/gather
// flip loop with flip/try limits, restarts, abort and a completion status.
module sat_thread_controller
    import sat_ctrl_pkg::*;
#(
    parameter int NSAT                      = 3,
    parameter int NUM_VARIABLES             = 2048,
    parameter int MAX_CLAUSE_MEMBERSHIP     = 20,
    parameter int UNSAT_CLAUSE_BUFFER_DEPTH = 2048,
    parameter int CONTROLLER_SIGNAL_WIDTH   = 14,
    parameter int FLIP_CNT_WIDTH            = 32,
    parameter int TRY_CNT_WIDTH             = 16,
    parameter int EVAL_WAIT_CYCLES          = 1,
    localparam int VAW      = vaw_f(NUM_VARIABLES),
    localparam int LAW      = law_f(NUM_VARIABLES),
    localparam int CT_WIDTH = ct_width_f(NUM_VARIABLES, NSAT, MAX_CLAUSE_MEMBERSHIP),
    localparam int UAW      = $clog2(UNSAT_CLAUSE_BUFFER_DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               start_run,
    input  logic                               abort,
    input  logic [FLIP_CNT_WIDTH-1:0]          max_flips_i,
    input  logic [TRY_CNT_WIDTH-1:0]           max_tries_i,
    input  logic [LAW:0]                       att_load_addr_i,
    input  logic [VAW+MAX_CLAUSE_MEMBERSHIP-1:0] att_load_data_i,
    input  logic                               att_load_valid_i,
    input  logic [VAW-1:0]                     ct_load_addr_i,
    input  logic [CT_WIDTH-1:0]                ct_load_data_i,
    input  logic                               ct_load_valid_i,
    input  logic [UAW-1:0]                     ucb_load_addr_i,
    input  logic [NSAT*LAW-1:0]                ucb_load_data_i,
    input  logic                               ucb_load_valid_i,
    output logic                               att_load_ready_o,
    output logic                               ct_load_ready_o,
    output logic                               ucb_load_ready_o,
    input  logic [UAW:0]                       unsat_buffer_count_i,
    input  logic                               restart_done_i,
    output logic [CONTROLLER_SIGNAL_WIDTH-1:0] control_signal_o,
    output logic                               att_wr_en_o,
    output logic [LAW:0]                       att_wr_addr_o,
    output logic [VAW+MAX_CLAUSE_MEMBERSHIP-1:0] att_wr_data_o,
    output logic                               ct_wr_en_o,
    output logic [VAW-1:0]                     ct_wr_addr_o,
    output logic [CT_WIDTH-1:0]                ct_wr_data_o,
    output logic                               ucb_setup_wr_en_o,
    output logic [UAW-1:0]                     ucb_setup_wr_addr_o,
    output logic [NSAT*LAW-1:0]                ucb_setup_wr_data_o,
    output logic                               ucb_setup_o,
    output logic                               restart_o,
    output logic                               done,
    output logic                               load_done,
    output logic                               busy,
    output logic [1:0]                         status_o,
    output logic [FLIP_CNT_WIDTH-1:0]          flip_count_o,
    output logic [TRY_CNT_WIDTH-1:0]           try_count_o
);

    localparam int WCW = (EVAL_WAIT_CYCLES > 1) ? $clog2(EVAL_WAIT_CYCLES) : 1;
    localparam logic [WCW-1:0] WAIT_LOAD = WCW'(EVAL_WAIT_CYCLES - 1);

    state_e                    state, state_nxt;
    status_e                   status_q, finish_code;
    logic [WCW-1:0]            wait_cnt;
    logic [FLIP_CNT_WIDTH-1:0] flip_count, max_flips_q;
    logic [TRY_CNT_WIDTH-1:0]  try_count, max_tries_q;
    logic [TRY_CNT_WIDTH:0]    try_next, tries_eff;
    logic                      load_done_q;
    logic                      latch_run, flip_inc, restart_ack, start_acc, finish;
    logic                      any_valid, in_run;

    assign any_valid = att_load_valid_i | ct_load_valid_i | ucb_load_valid_i;
    assign in_run    = state inside {S_SELECT_UNSAT, S_READ_CLAUSETAB, S_READ_VARTAB,
                                     S_EVAL_CLAUSE, S_WAIT_EVAL, S_GATHER_UNSAT,
                                     S_WAIT_GATHER, S_CHECK_SOL, S_RESTART};
    assign try_next  = {1'b0, try_count} + 1'b1;
    // A zero try limit still allows a single try.
    assign tries_eff = (max_tries_q == '0) ? {{TRY_CNT_WIDTH{1'b0}}, 1'b1} : {1'b0, max_tries_q};

    sat_load_arbiter #(
        .ATT_AW(LAW + 1),
        .ATT_DW(VAW + MAX_CLAUSE_MEMBERSHIP),
        .CT_AW (VAW),
        .CT_DW (CT_WIDTH),
        .UCB_AW(UAW),
        .UCB_DW(NSAT * LAW)
    ) u_load_arbiter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_active(state == S_LOAD),
        .att_addr   (att_load_addr_i),
        .att_data   (att_load_data_i),
        .att_valid  (att_load_valid_i),
        .ct_addr    (ct_load_addr_i),
        .ct_data    (ct_load_data_i),
        .ct_valid   (ct_load_valid_i),
        .ucb_addr   (ucb_load_addr_i),
        .ucb_data   (ucb_load_data_i),
        .ucb_valid  (ucb_load_valid_i),
        .att_ready  (att_load_ready_o),
        .ct_ready   (ct_load_ready_o),
        .ucb_ready  (ucb_load_ready_o),
        .att_wr_en  (att_wr_en_o),
        .att_wr_addr(att_wr_addr_o),
        .att_wr_data(att_wr_data_o),
        .ct_wr_en   (ct_wr_en_o),
        .ct_wr_addr (ct_wr_addr_o),
        .ct_wr_data (ct_wr_data_o),
        .ucb_wr_en  (ucb_setup_wr_en_o),
        .ucb_wr_addr(ucb_setup_wr_addr_o),
        .ucb_wr_data(ucb_setup_wr_data_o),
        .ucb_setup  (ucb_setup_o)
    );

    always_comb begin
        state_nxt   = state;
        latch_run   = 1'b0;
        flip_inc    = 1'b0;
        restart_ack = 1'b0;
        start_acc   = 1'b0;
        finish      = 1'b0;
        finish_code = ST_NONE;
        case (state)
            S_IDLE:           if (start) begin state_nxt = S_LOAD; start_acc = 1'b1; end
            S_LOAD:           if (!any_valid && start_run) begin
                                  state_nxt = S_SELECT_UNSAT;
                                  latch_run = 1'b1;
                              end
            S_SELECT_UNSAT:   state_nxt = S_READ_CLAUSETAB;
            S_READ_CLAUSETAB: state_nxt = S_READ_VARTAB;
            S_READ_VARTAB:    state_nxt = S_EVAL_CLAUSE;
            S_EVAL_CLAUSE:    state_nxt = S_WAIT_EVAL;
            S_WAIT_EVAL:      if (wait_cnt == '0) state_nxt = S_GATHER_UNSAT;
            S_GATHER_UNSAT:   state_nxt = S_WAIT_GATHER;
            S_WAIT_GATHER:    begin state_nxt = S_CHECK_SOL; flip_inc = 1'b1; end
            S_CHECK_SOL: begin
                if (unsat_buffer_count_i == '0) begin
                    state_nxt   = S_DONE;
                    finish      = 1'b1;
                    finish_code = ST_SAT;
                end else if (flip_count >= max_flips_q) begin
                    if (try_next < tries_eff) begin
                        state_nxt = S_RESTART;
                    end else begin
                        state_nxt   = S_DONE;
                        finish      = 1'b1;
                        finish_code = ST_EXHAUSTED;
                    end
                end else begin
                    state_nxt = S_SELECT_UNSAT;
                end
            end
            S_RESTART:        if (restart_done_i) begin
                                  state_nxt   = S_SELECT_UNSAT;
                                  restart_ack = 1'b1;
                              end
            S_DONE:           if (start) begin state_nxt = S_LOAD; start_acc = 1'b1; end
            default:          state_nxt = S_IDLE;
        endcase
        // Abort wins over every other transition while solving.
        if (abort && in_run) begin
            state_nxt   = S_DONE;
            finish      = 1'b1;
            finish_code = ST_ABORTED;
            flip_inc    = 1'b0;
            restart_ack = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            flip_count  <= '0;
            try_count   <= '0;
            status_q    <= ST_NONE;
            load_done_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_EVAL_CLAUSE)
                wait_cnt <= WAIT_LOAD;
            else if (state == S_WAIT_EVAL && wait_cnt != '0)
                wait_cnt <= wait_cnt - 1'b1;
            if (latch_run) begin
                flip_count <= '0;
                try_count  <= '0;
            end else if (restart_ack) begin
                flip_count <= '0;
                try_count  <= try_count + 1'b1;
            end else if (flip_inc && flip_count != '1) begin
                flip_count <= flip_count + 1'b1;
            end
            if (start_acc) begin
                status_q    <= ST_NONE;
                load_done_q <= 1'b0;
            end else begin
                if (finish)    status_q    <= finish_code;
                if (latch_run) load_done_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (latch_run) begin
            max_flips_q <= max_flips_i;
            max_tries_q <= max_tries_i;
        end
    end

    always_comb begin
        control_signal_o = '0;
        case (state)
            S_SELECT_UNSAT: begin
                control_signal_o[CTL_SEL_VALID] = 1'b1;
                control_signal_o[CTL_SEL_REQ]   = 1'b1;
            end
            S_READ_VARTAB: begin
                control_signal_o[CTL_VT_RD]       = 1'b1;
                control_signal_o[CTL_SRC_LO +: 2] = 2'b01;
            end
            S_EVAL_CLAUSE: begin
                control_signal_o[CTL_EVAL_LO +: 2] = 2'b01;
                control_signal_o[CTL_EVAL_EN]      = 1'b1;
                control_signal_o[CTL_SRC_LO +: 2]  = 2'b10;
            end
            S_GATHER_UNSAT: control_signal_o[CTL_GATHER] = 1'b1;
            S_WAIT_GATHER:  control_signal_o[CTL_FLIP]   = 1'b1;
            default: ;
        endcase
    end

    assign restart_o    = (state == S_RESTART);
    assign done         = (state == S_DONE);
    assign busy         = (state != S_IDLE) && (state != S_DONE);
    assign load_done    = load_done_q;
    assign status_o     = status_q;
    assign flip_count_o = flip_count;
    assign try_count_o  = try_count;

endmodule

// File: tb/tb_sat_thread_controller.sv
// Directed bench for sat_thread_controller with a cycle-level behavioural model
// compared against every output on each falling edge.
module tb_sat_thread_controller;

    localparam int E    = 3;
    localparam int VAW  = 11;
    localparam int LAW  = 12;
    localparam int CTW  = 480;
    localparam int UAW  = 11;
    localparam int LAST = 6 + E;  // position of the solution check within one flip

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start_run = 1'b0, abort = 1'b0;
    logic [31:0] max_flips = '0;
    logic [15:0] max_tries = '0;
    logic [LAW:0] att_a = '0;
    logic [VAW+19:0] att_d = '0;
    logic att_v = 1'b0;
    logic [VAW-1:0] ct_a = '0;
    logic [CTW-1:0] ct_d = '0;
    logic ct_v = 1'b0;
    logic [UAW-1:0] ucb_a = '0;
    logic [3*LAW-1:0] ucb_d = '0;
    logic ucb_v = 1'b0;
    logic [UAW:0] unsat = 12'd3;
    logic restart_done = 1'b0;

    logic att_rdy, ct_rdy, ucb_rdy;
    logic [13:0] ctrl;
    logic att_we, ct_we, ucb_we, ucb_setup;
    logic [LAW:0] att_wa;
    logic [VAW+19:0] att_wd;
    logic [VAW-1:0] ct_wa;
    logic [CTW-1:0] ct_wd;
    logic [UAW-1:0] ucb_wa;
    logic [3*LAW-1:0] ucb_wd;
    logic restart_o, done, load_done, busy;
    logic [1:0] status_o;
    logic [31:0] flip_count_o;
    logic [15:0] try_count_o;

    sat_thread_controller #(.EVAL_WAIT_CYCLES(E)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_run(start_run), .abort(abort),
        .max_flips_i(max_flips), .max_tries_i(max_tries),
        .att_load_addr_i(att_a), .att_load_data_i(att_d), .att_load_valid_i(att_v),
        .ct_load_addr_i(ct_a), .ct_load_data_i(ct_d), .ct_load_valid_i(ct_v),
        .ucb_load_addr_i(ucb_a), .ucb_load_data_i(ucb_d), .ucb_load_valid_i(ucb_v),
        .att_load_ready_o(att_rdy), .ct_load_ready_o(ct_rdy), .ucb_load_ready_o(ucb_rdy),
        .unsat_buffer_count_i(unsat), .restart_done_i(restart_done),
        .control_signal_o(ctrl),
        .att_wr_en_o(att_we), .att_wr_addr_o(att_wa), .att_wr_data_o(att_wd),
        .ct_wr_en_o(ct_we), .ct_wr_addr_o(ct_wa), .ct_wr_data_o(ct_wd),
        .ucb_setup_wr_en_o(ucb_we), .ucb_setup_wr_addr_o(ucb_wa), .ucb_setup_wr_data_o(ucb_wd),
        .ucb_setup_o(ucb_setup), .restart_o(restart_o), .done(done), .load_done(load_done),
        .busy(busy), .status_o(status_o), .flip_count_o(flip_count_o), .try_count_o(try_count_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    function automatic logic [CTW-1:0] ctd(input int i);
        return {15{32'hC0DE0000 | 32'(i)}};
    endfunction

    // Model: mode 0 idle, 1 load, 2 flipping (m_pos = cycle within the flip), 3 restart, 4 done.
    int m_mode = 0, m_pos = 0, m_tries = 0, m_status = 0, m_lim_t = 1;
    longint m_flips = 0, m_lim_f = 0;
    bit m_ld = 0, chk_en = 0;
    logic e_att_we = 0, e_ct_we = 0, e_ucb_we = 0;
    logic [LAW:0] e_att_a = '0;
    logic [VAW+19:0] e_att_d = '0;
    logic [VAW-1:0] e_ct_a = '0;
    logic [CTW-1:0] e_ct_d = '0;
    logic [UAW-1:0] e_ucb_a = '0;
    logic [3*LAW-1:0] e_ucb_d = '0;

    function automatic logic [13:0] exp_ctrl();
        if (m_mode != 2)       return 14'h0000;
        if (m_pos == 0)        return 14'h2001;
        if (m_pos == 2)        return 14'h0208;
        if (m_pos == 3)        return 14'h0070;
        if (m_pos == 4 + E)    return 14'h0004;
        if (m_pos == 5 + E)    return 14'h0002;
        return 14'h0000;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0; m_pos = 0; m_flips = 0; m_tries = 0; m_status = 0; m_ld = 0;
            e_att_we = 0; e_ct_we = 0; e_ucb_we = 0;
            e_att_a = '0; e_att_d = '0; e_ct_a = '0; e_ct_d = '0; e_ucb_a = '0; e_ucb_d = '0;
            chk_en = 1;
        end else begin
            e_att_we = (m_mode == 1) && att_v;
            e_ct_we  = (m_mode == 1) && !att_v && ct_v;
            e_ucb_we = (m_mode == 1) && !att_v && !ct_v && ucb_v;
            if (e_att_we) begin e_att_a = att_a; e_att_d = att_d; end
            if (e_ct_we)  begin e_ct_a = ct_a;   e_ct_d = ct_d;   end
            if (e_ucb_we) begin e_ucb_a = ucb_a; e_ucb_d = ucb_d; end
            case (m_mode)
                0: if (start) begin m_mode = 1; m_ld = 0; m_status = 0; end
                1: if (!att_v && !ct_v && !ucb_v && start_run) begin
                       m_lim_f = max_flips;
                       m_lim_t = (max_tries == 0) ? 1 : int'(max_tries);
                       m_flips = 0; m_tries = 0; m_mode = 2; m_pos = 0; m_ld = 1;
                   end
                2, 3: begin
                    if (abort) begin
                        m_mode = 4; m_status = 3;
                    end else if (m_mode == 3) begin
                        if (restart_done) begin m_flips = 0; m_tries++; m_mode = 2; m_pos = 0; end
                    end else if (m_pos < LAST) begin
                        if (m_pos == 5 + E && m_flips < 64'hFFFF_FFFF) m_flips++;
                        m_pos++;
                    end else if (unsat == 0) begin
                        m_mode = 4; m_status = 1;
                    end else if (m_flips >= m_lim_f) begin
                        if (m_tries + 1 < m_lim_t) m_mode = 3;
                        else begin m_mode = 4; m_status = 2; end
                    end else begin
                        m_pos = 0;
                    end
                end
                4: if (start) begin m_mode = 1; m_status = 0; m_ld = 0; end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, (m_mode >= 1 && m_mode <= 3));
            check("done", done, (m_mode == 4));
            check("restart_o", restart_o, (m_mode == 3));
            check("load_done", load_done, m_ld);
            check("status", status_o, m_status);
            check("flip_count", flip_count_o, m_flips);
            check("try_count", try_count_o, m_tries);
            check("control", ctrl, exp_ctrl());
            check("att_ready", att_rdy, (m_mode == 1));
            check("ct_ready", ct_rdy, (m_mode == 1) && !att_v);
            check("ucb_ready", ucb_rdy, (m_mode == 1) && !att_v && !ct_v);
            check("att_wr_en", att_we, e_att_we);
            check("att_wr_addr", att_wa, e_att_a);
            check("att_wr_data", att_wd, e_att_d);
            check("ct_wr_en", ct_we, e_ct_we);
            check("ct_wr_addr", ct_wa, e_ct_a);
            check("ct_wr_data", ct_wd, e_ct_d);
            check("ucb_wr_en", ucb_we, e_ucb_we);
            check("ucb_setup", ucb_setup, e_ucb_we);
            check("ucb_wr_addr", ucb_wa, e_ucb_a);
            check("ucb_wr_data", ucb_wd, e_ucb_d);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic begin_run(input logic [31:0] flips, input logic [15:0] tries);
        start = 1; start_run = 1; max_flips = flips; max_tries = tries;
        step();
        start = 0;
        step();
        start_run = 0;
    endtask

    int run_len, max_run, restarts;

    initial begin
        repeat (3) step();
        check("reset_busy", busy, 0);
        check("reset_status", status_o, 0);
        check("reset_ctrl", ctrl, 0);
        rst_n = 1;
        step(); start = 1;
        step(); start = 0;

        // ATT beats with a competing CT beat held valid
        for (int i = 0; i < 3; i++) begin
            att_v = 1; att_a = 13'h100 + 13'(i); att_d = 31'h1234_0000 + 31'(i);
            ct_v = 1; ct_a = 11'h20; ct_d = ctd(0);
            step();
            if (i == 0) begin
                check("lit_ct_ready_blocked", ct_rdy, 0);
                check("lit_att_ready", att_rdy, 1);
                check("lit_att_first_addr", att_wa, 13'h100);
                check("lit_ct_no_write", ct_we, 0);
            end
        end
        att_v = 0;
        for (int i = 0; i < 2; i++) begin
            ct_a = 11'h20 + 11'(i); ct_d = ctd(i);
            step();
            if (i == 0) check("lit_ct_after_att", ct_wa, 11'h20);
        end
        ct_v = 0;
        for (int i = 0; i < 4; i++) begin
            ucb_v = 1; ucb_a = 11'(i); ucb_d = 36'hA_0000_0000 + 36'(i);
            start_run = (i == 3); max_flips = 5; max_tries = 1; unsat = 3;
            step();
        end
        check("lit_exit_blocked", att_rdy, 1);
        check("lit_ucb_last_addr", ucb_wa, 11'd3);
        check("lit_load_done_low", load_done, 0);
        ucb_v = 0; start_run = 1;
        step();
        start_run = 0;
        check("lit_load_done_rise", load_done, 1);
        check("lit_first_select", ctrl, 14'h2001);

        // exhausted after 5 flips, one try
        for (int i = 0; i < 200 && !done; i++) step();
        check("A_done", done, 1);
        check("A_status", status_o, 2'b10);
        check("A_flips", flip_count_o, 5);
        check("A_tries", try_count_o, 0);

        // unsat count reaches zero before the second check
        start = 1; start_run = 1; max_flips = 10; max_tries = 1;
        step();
        start = 0;
        check("B_status_cleared", status_o, 0);
        step();
        start_run = 0;
        for (int i = 0; i < 50 && flip_count_o != 1; i++) step();
        check("B_first_flip", flip_count_o, 1);
        step();
        unsat = 0;
        for (int i = 0; i < 50 && !done; i++) step();
        check("B_status", status_o, 2'b01);
        check("B_flips", flip_count_o, 2);
        unsat = 3;

        // multi-try with a slow restart acknowledge
        begin_run(2, 3);
        run_len = 0; max_run = 0; restarts = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            if (restart_o) begin
                run_len++;
                if (run_len == 1) restarts++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            restart_done = (run_len >= 4);
        end
        restart_done = 0;
        check("C_restart_hold", max_run >= 4, 1);
        check("C_restarts", restarts, 2);
        check("C_status", status_o, 2'b10);
        check("C_tries", try_count_o, 2);
        check("C_flips", flip_count_o, 2);

        // abort while waiting on evaluation
        begin_run(100, 1);
        for (int i = 0; i < 50 && !ctrl[5]; i++) step();
        check("D_eval_seen", ctrl[5], 1);
        step();
        check("D_in_wait_eval", busy, 1);
        abort = 1;
        step();
        abort = 0;
        check("D_done", done, 1);
        check("D_status", status_o, 2'b11);

        // reset during restart; max_flips=0 still flips once
        begin_run(0, 3);
        for (int i = 0; i < 50 && !restart_o; i++) step();
        check("E_restart", restart_o, 1);
        check("E_one_flip", flip_count_o, 1);
        rst_n = 0;
        step();
        check("E_reset_restart", restart_o, 0);
        check("E_reset_busy", busy, 0);
        check("E_reset_flips", flip_count_o, 0);
        rst_n = 1; start_run = 1;
        step();
        step();
        check("E_idle_after_reset", busy, 0);
        start_run = 0; start = 1;
        step();
        start = 0;
        check("E_reload_busy", busy, 1);
        check("E_reload_ready", att_rdy, 1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
